// File: rtl/flat_shift_pkg.sv
// flat_shift_pkg: shared direction constants and layout/width helpers for flat_shift_array
package flat_shift_pkg;
    localparam logic FWD = 1'b0;
    localparam logic REV = 1'b1;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction
    // Ascending ranges reverse the position so logical (0,0) lands on the MSB
    function automatic int flat_pos(input int r, input int c, input int rows, input int cols,
                                    input int row_asc, input int col_asc);
        return (row_asc != 0 ? rows - 1 - r : r) * cols + (col_asc != 0 ? cols - 1 - c : c);
    endfunction
endpackage

// File: rtl/flat_shift_tap.sv
// flat_shift_tap: combinational window read of one row, zero-filled past the row end
module flat_shift_tap
    import flat_shift_pkg::*;
#(
    parameter int ROWS = 3,
    parameter int COLS = 5,
    parameter int WIN  = 2
) (
    input  logic [ROWS*COLS-1:0]    cells,
    input  logic [idx_w(ROWS)-1:0]  tap_row,
    input  logic [idx_w(COLS)-1:0]  tap_col,
    output logic [WIN-1:0]          win
);
    logic [ROWS*COLS-1:0] row_bits;
    always_comb begin
        row_bits = cells >> (int'(tap_row) * COLS + int'(tap_col));
        win = '0;
        for (int k = 0; k < WIN; k++)
            win[k] = (int'(tap_col) + k < COLS && int'(tap_row) < ROWS) ? row_bits[k] : 1'b0;
    end
endmodule

// File: rtl/flat_shift_array.sv
// flat_shift_array: 2-D shift-register array with multi-bit reversible shift, load, clear,
// saturating fill count and a registered tap window, exposed as one flattened vector
module flat_shift_array
    import flat_shift_pkg::*;
#(
    parameter int ROWS    = 3,
    parameter int COLS    = 5,
    parameter int ROW_LO  = 0,
    parameter int COL_LO  = 0,
    parameter int ROW_ASC = 0,
    parameter int COL_ASC = 0,
    parameter int STEP    = 1,
    parameter int WIN     = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         shift_en,
    input  logic                         dir,
    input  logic [STEP-1:0]              in,
    input  logic                         load,
    input  logic [ROWS*COLS-1:0]         load_data,
    input  logic [idx_w(ROWS)-1:0]       tap_row,
    input  logic [idx_w(COLS)-1:0]       tap_col,
    output logic [ROWS*COLS-1:0]         out,
    output logic [WIN-1:0]               tap_data,
    output logic [cnt_w(ROWS*COLS)-1:0]  fill,
    output logic                         full
);
    localparam int N  = ROWS * COLS;
    localparam int FW = cnt_w(N);
    logic [N-1:0] cells, load_cells, in_rev, shifted;
    logic [FW-1:0] fill_inc;
    logic [WIN-1:0] win;
    genvar i, j;
    // Walk the declared index ranges; cells is held in logical order L = r*COLS + c
    for (i = ROW_LO; i < ROW_LO + ROWS; i++) begin : g_row
        for (j = COL_LO; j < COL_LO + COLS; j++) begin : g_col
            localparam int L = (i - ROW_LO) * COLS + (j - COL_LO);
            localparam int F = flat_pos(i - ROW_LO, j - COL_LO, ROWS, COLS, ROW_ASC, COL_ASC);
            assign out[F] = cells[L];
            assign load_cells[L] = load_data[F];
        end
    end
    always_comb begin
        in_rev = '0;
        for (int k = 0; k < STEP; k++)
            in_rev[N-1-k] = in[k];
        shifted = (dir == REV) ? ((cells >> STEP) | in_rev) : ((cells << STEP) | N'(in));
        fill_inc = (int'(fill) + STEP >= N) ? FW'(N) : fill + FW'(STEP);
    end
    flat_shift_tap #(.ROWS(ROWS), .COLS(COLS), .WIN(WIN)) u_tap (
        .cells   (cells),
        .tap_row (tap_row),
        .tap_col (tap_col),
        .win     (win)
    );
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cells    <= '0;
            fill     <= '0;
            full     <= 1'b0;
            tap_data <= '0;
        end else begin
            tap_data <= win;
            if (clear) begin
                cells <= '0;
                fill  <= '0;
                full  <= 1'b0;
            end else if (load) begin
                cells <= load_cells;
                fill  <= FW'(N);
                full  <= 1'b1;
            end else if (shift_en) begin
                cells <= shifted;
                fill  <= fill_inc;
                full  <= (fill_inc == FW'(N));
            end
        end
    end
endmodule
